// File: rtl/alu_mul_sequencer.sv
// -----------------------------------------------------------------------------
// alu_mul_sequencer
//
// Drives a shared N-bit combinational ALU to compute an unsigned N x N
// shift-add multiply. It takes one request at a time and issues one ALU
// opcode per cycle: ADD (0000) or SHIFT LEFT (1000). It returns the low N bits
// of the product and flags any overflow.
//
// Ports:
//   clk, rst          single clock; synchronous active-high reset
//   req_valid/ready   request handshake; req_a = multiplicand, req_b = multiplier
//   resp_valid/ready  response handshake; resp_product = (a*b) mod 2^N,
//                     resp_overflow = true product >= 2^N,
//                     resp_zero = (resp_product == 0)
//   alu_a, alu_b,     operands and opcode driven to the ALU (Moore, from
//   alu_opcode        state and registers only)
//   alu_out,          ALU result and carry, consumed in the same cycle
//   alu_carry_flag
// -----------------------------------------------------------------------------
module alu_mul_sequencer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req_a,
    input  logic [N-1:0] req_b,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [N-1:0] resp_product,
    output logic         resp_overflow,
    output logic         resp_zero,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_opcode,
    input  logic [N-1:0] alu_out,
    input  logic         alu_carry_flag
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SHL = 4'b1000;
    localparam logic [3:0] OP_NOP = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        SHIFT,
        DONE
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [N-1:0] acc;
    logic [N-1:0] mcand;
    logic [N-1:0] mplier;
    logic         ovf;
    // Sticky: mcand has shifted a set bit out of the top, so any later ADD
    // uses a truncated multiplicand and the true product cannot fit in N bits.
    logic         lost;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            ovf    <= 1'b0;
            lost   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        acc    <= '0;
                        mcand  <= req_a;
                        mplier <= req_b;
                        ovf    <= 1'b0;
                        lost   <= 1'b0;
                    end
                end
                ADD: begin
                    acc <= alu_out;
                    ovf <= ovf | alu_carry_flag | lost;
                end
                SHIFT: begin
                    mcand  <= alu_out;
                    lost   <= lost | mcand[N-1];
                    mplier <= mplier >> 1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next    = state;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_product  = '0;
        resp_overflow = 1'b0;
        resp_zero     = 1'b0;
        alu_opcode    = OP_NOP;
        alu_a         = '0;
        alu_b         = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_b == '0)
                        state_next = DONE;
                    else if (req_b[0])
                        state_next = ADD;
                    else
                        state_next = SHIFT;
                end
            end
            ADD: begin
                alu_opcode = OP_ADD;
                alu_a      = acc;
                alu_b      = mcand;
                // No multiplier bits left above bit 0: this was the last add.
                state_next = (mplier[N-1:1] == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                alu_opcode = OP_SHL;
                alu_a      = mcand;
                alu_b      = {{(N-1){1'b0}}, 1'b1};
                // mplier[1] becomes bit 0 after this shift.
                state_next = mplier[1] ? ADD : SHIFT;
            end
            DONE: begin
                resp_valid    = 1'b1;
                resp_product  = acc;
                resp_overflow = ovf;
                resp_zero     = (acc == '0);
                if (resp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_mul_sequencer
//
// Self-checking bench for alu_mul_sequencer (N=8). It contains a behavioural
// model of the attached ALU (ADD and SHIFT LEFT). A table of directed
// multiplies is checked for product, flags, opcode counts and latency. Hand
// sequences cover response back-pressure, requests presented while busy, and
// reset during an operation.
// -----------------------------------------------------------------------------
module tb_alu_mul_sequencer;

    localparam int N = 8;
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SHL = 4'b1000;
    localparam logic [3:0] OP_NOP = 4'b1111;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [N-1:0] req_a;
    logic [N-1:0] req_b;
    logic         resp_valid;
    logic         resp_ready;
    logic [N-1:0] resp_product;
    logic         resp_overflow;
    logic         resp_zero;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   alu_opcode;
    logic [N-1:0] alu_out;
    logic         alu_carry_flag;

    int total;
    int bad;

    alu_mul_sequencer #(.N(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_product  (resp_product),
        .resp_overflow (resp_overflow),
        .resp_zero     (resp_zero),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_opcode    (alu_opcode),
        .alu_out       (alu_out),
        .alu_carry_flag(alu_carry_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the shared combinational ALU.
    logic [N:0] alu_wide;
    always_comb begin
        alu_wide = '0;
        case (alu_opcode)
            OP_ADD:  alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
            OP_SHL:  alu_wide = {1'b0, alu_a} << alu_b;
            default: alu_wide = '0;
        endcase
        alu_out        = alu_wide[N-1:0];
        alu_carry_flag = alu_wide[N];
    end

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] prod;
        logic         ovf;
        logic         zero;
        int           adds;
        int           shifts;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Run one multiply with resp_ready held high. Opcodes are counted at each
    // negedge until resp_valid appears; the response must appear exactly
    // adds+shifts edges after the accept edge.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] prod, input logic ovf, input logic zero,
                          input int adds, input int shifts);
        int   k;
        int   na;
        int   ns;
        logic busy_bad;
        @(negedge clk);
        chk("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_a      = a;
        req_b      = b;
        req_valid  = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        k = 0; na = 0; ns = 0; busy_bad = 1'b0;
        while (!resp_valid && k < 40) begin
            if (alu_opcode == OP_ADD) na++;
            else if (alu_opcode == OP_SHL) ns++;
            else busy_bad = 1'b1;
            if (req_ready) busy_bad = 1'b1;
            @(negedge clk);
            k++;
        end
        chk("resp_valid_seen", {31'd0, resp_valid}, 32'd1);
        chk("add_count", na, adds);
        chk("shift_count", ns, shifts);
        chk("latency", k, adds + shifts);
        chk("product", {24'd0, resp_product}, {24'd0, prod});
        chk("overflow", {31'd0, resp_overflow}, {31'd0, ovf});
        chk("zero", {31'd0, resp_zero}, {31'd0, zero});
        chk("busy_ctrl", {31'd0, busy_bad}, 32'd0);
        chk("done_opcode", {28'd0, alu_opcode}, {28'd0, OP_NOP});
        @(negedge clk);
        chk("back_to_idle", {30'd0, req_ready, resp_valid}, 32'd2);
    endtask

    initial begin
        int   k;
        logic flag;

        total = 0;
        bad   = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;

        //          a    b    prod ovf zero adds shifts
        vecs[0] = '{8'd6,   8'd7,   8'd42,  1'b0, 1'b0, 3, 2};
        vecs[1] = '{8'd5,   8'd0,   8'd0,   1'b0, 1'b1, 0, 0};
        vecs[2] = '{8'd16,  8'd16,  8'h00,  1'b1, 1'b1, 1, 4};
        vecs[3] = '{8'd255, 8'd255, 8'h01,  1'b1, 1'b0, 8, 7};
        vecs[4] = '{8'd1,   8'd128, 8'd128, 1'b0, 1'b0, 1, 7};
        vecs[5] = '{8'd15,  8'd17,  8'd255, 1'b0, 1'b0, 2, 4};
        vecs[6] = '{8'd100, 8'd3,   8'd44,  1'b1, 1'b0, 2, 1};
        vecs[7] = '{8'd128, 8'd2,   8'd0,   1'b1, 1'b1, 1, 1};
        vecs[8] = '{8'd0,   8'd9,   8'd0,   1'b0, 1'b1, 2, 3};

        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_opcode", {28'd0, alu_opcode}, {28'd0, OP_NOP});
        chk("rst_alu_ab", {16'd0, alu_a, alu_b}, 32'd0);
        chk("rst_resp", {22'd0, resp_product, resp_overflow, resp_zero}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].ovf, vecs[i].zero,
                   vecs[i].adds, vecs[i].shifts);

        // Back-pressure: 3*5 with resp_ready low; a request is pushed while
        // busy and while waiting in DONE and must not be accepted.
        @(negedge clk);
        resp_ready = 1'b0;
        req_a      = 8'd3;
        req_b      = 8'd5;
        req_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_a = 8'd77;
        req_b = 8'd11;
        k = 0;
        flag = 1'b0;
        while (!resp_valid && k < 40) begin
            if (req_ready) flag = 1'b1;
            @(negedge clk);
            k++;
        end
        chk("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("hold_latency", k, 4);
        for (int c = 0; c < 10; c++) begin
            req_valid = c[0];
            if (!resp_valid || resp_product != 8'd15 || req_ready || resp_zero
                || resp_overflow || alu_opcode != OP_NOP)
                flag = 1'b1;
            @(negedge clk);
        end
        chk("hold_stable", {31'd0, flag}, 32'd0);
        chk("hold_product", {24'd0, resp_product}, 32'd15);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("hold_release_idle", {30'd0, req_ready, resp_valid}, 32'd2);
        flag = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (resp_valid || alu_opcode != OP_NOP || !req_ready) flag = 1'b1;
            @(negedge clk);
        end
        chk("no_ghost_request", {31'd0, flag}, 32'd0);

        // Reset during the second cycle of 200*3 aborts the operation.
        req_a     = 8'd200;
        req_b     = 8'd3;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort_opcode", {28'd0, alu_opcode}, {28'd0, OP_NOP});
        chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
        flag = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (resp_valid || alu_opcode != OP_NOP) flag = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_resp", {31'd0, flag}, 32'd0);
        run_op(8'd200, 8'd2, 8'h90, 1'b1, 1'b0, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
